snake_score_keeper: RTL and testbench

Producer side of the score-to-OSD interface: counts food events from the game core and maintains the binary score (0–99) plus a tear-free, frame-synchronous pair of BCD digits for the on-screen digit renderer. A sequential double-dabble converter in the pixel clock domain replaces the combinational divide/modulo. A high-score register survives game restarts. Sits between the snake game FSM and the score OSD overlay in the VGA pipeline.

---
 rtl/snake_score_keeper_pkg.sv | 12 +
 rtl/snake_bin2bcd_seq.sv | 65 ++++++
 rtl/snake_score_keeper.sv | 114 +++++++++++
 tb/tb_snake_score_keeper.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_score_keeper_pkg.sv
// Shared types and widths for the snake score keeper and its BCD converter.
package snake_score_keeper_pkg;
  localparam int SCORE_W           = 7;
  localparam int BCD_W             = 4;
  localparam int MAX_SCORE_DEFAULT = 99;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_DONE
  } conv_state_e;
endpackage

// File: rtl/snake_bin2bcd_seq.sv
// Sequential double-dabble: 7-bit binary to two BCD digits, one shift per cycle.
module snake_bin2bcd_seq
  import snake_score_keeper_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [SCORE_W-1:0] bin_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [BCD_W-1:0]   tens_o,
  output logic [BCD_W-1:0]   ones_o
);
  localparam int SH_W     = SCORE_W + 2*BCD_W;
  localparam int ONES_LSB = SCORE_W;
  localparam int TENS_LSB = SCORE_W + BCD_W;
  localparam logic [2:0] LAST_IT = 3'(SCORE_W - 1);

  conv_state_e         state_q, state_d;
  logic [SH_W-1:0]     sh_q, sh_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [BCD_W-1:0]    tens_cur, ones_cur, tens_adj, ones_adj;

  assign tens_cur = sh_q[TENS_LSB +: BCD_W];
  assign ones_cur = sh_q[ONES_LSB +: BCD_W];
  assign tens_adj = (tens_cur >= 4'd5) ? tens_cur + 4'd3 : tens_cur;
  assign ones_adj = (ones_cur >= 4'd5) ? ones_cur + 4'd3 : ones_cur;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: if (start_i) begin
        sh_d    = {{(2*BCD_W){1'b0}}, bin_i};
        cnt_d   = '0;
        state_d = ST_CONV;
      end
      ST_CONV: begin
        sh_d  = {tens_adj, ones_adj, sh_q[SCORE_W-1:0]} << 1;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_IT) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);
  assign tens_o = tens_cur;
  assign ones_o = ones_cur;
endmodule

// File: rtl/snake_score_keeper.sv
// Score counter, BCD conversion hand-off and frame-synchronous digit latch.
// Optional high-score tracking is enabled by defining SNAKE_HISCORE_EN.
module snake_score_keeper
  import snake_score_keeper_pkg::*;
#(
  parameter int MAX_SCORE       = MAX_SCORE_DEFAULT,
  parameter int POINTS_PER_FOOD = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               eat_pulse_i,
  input  logic               game_over_i,
  input  logic               game_restart_i,
  input  logic               frame_tick_i,
  output logic [SCORE_W-1:0] score_o,
  output logic [BCD_W-1:0]   score_tens_o,
  output logic [BCD_W-1:0]   score_ones_o,
  output logic               score_update_o,
  output logic [SCORE_W-1:0] high_score_o
);
  typedef logic [SCORE_W:0] sum_t;
  localparam sum_t PTS  = sum_t'(POINTS_PER_FOOD);
  localparam sum_t MAXV = sum_t'(MAX_SCORE);

  logic [SCORE_W-1:0] score_q, score_d;
  logic               score_wr;
  sum_t               sum;
  logic               dirty_q, dirty_d, capture;
  logic               cv_busy, cv_done;
  logic [BCD_W-1:0]   cv_tens, cv_ones;
  logic [BCD_W-1:0]   pend_tens_q, pend_ones_q, disp_tens_q, disp_ones_q;
  logic               pend_vld_q, upd_q, present;

  assign sum = {1'b0, score_q} + PTS;

  always_comb begin
    score_d  = score_q;
    score_wr = 1'b0;
    if (game_restart_i) begin
      score_d  = '0;
      score_wr = 1'b1;
    end else if (eat_pulse_i && !game_over_i) begin
      score_d  = (sum > MAXV) ? MAXV[SCORE_W-1:0] : sum[SCORE_W-1:0];
      score_wr = 1'b1;
    end
  end

  // A write in the capture cycle must survive so the newer value gets converted.
  assign capture = dirty_q & ~cv_busy;
  assign dirty_d = score_wr | (dirty_q & ~capture);
  assign present = frame_tick_i & pend_vld_q;

  snake_bin2bcd_seq u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (dirty_q),
    .bin_i   (score_q),
    .busy_o  (cv_busy),
    .done_o  (cv_done),
    .tens_o  (cv_tens),
    .ones_o  (cv_ones)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q     <= '0;
      dirty_q     <= 1'b0;
      pend_tens_q <= '0;
      pend_ones_q <= '0;
      pend_vld_q  <= 1'b0;
      disp_tens_q <= '0;
      disp_ones_q <= '0;
      upd_q       <= 1'b0;
    end else begin
      score_q <= score_d;
      dirty_q <= dirty_d;
      if (cv_done) begin
        pend_tens_q <= cv_tens;
        pend_ones_q <= cv_ones;
      end
      // Tick sees the old valid; a same-cycle result waits for the next tick.
      pend_vld_q <= cv_done | (pend_vld_q & ~frame_tick_i);
      upd_q      <= present;
      if (present) begin
        disp_tens_q <= pend_tens_q;
        disp_ones_q <= pend_ones_q;
      end
    end
  end

  assign score_o        = score_q;
  assign score_tens_o   = disp_tens_q;
  assign score_ones_o   = disp_ones_q;
  assign score_update_o = upd_q;

`ifdef SNAKE_HISCORE_EN
  logic               go_q;
  logic [SCORE_W-1:0] hs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_q <= 1'b0;
      hs_q <= '0;
    end else begin
      go_q <= game_over_i;
      if (game_over_i && !go_q && (score_q > hs_q)) hs_q <= score_q;
    end
  end

  assign high_score_o = hs_q;
`else
  assign high_score_o = '0;
`endif
endmodule

// File: tb/tb_snake_score_keeper.sv
// Bench for snake_score_keeper: two instances (1 and 3 points per food) against a behavioural model.
module tb_snake_score_keeper;
`ifdef SNAKE_HISCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic eat = 1'b0, go = 1'b0, rs = 1'b0, tick = 1'b0;
  logic [6:0] score_a [2];
  logic [6:0] hs_a    [2];
  logic [3:0] tens_a  [2];
  logic [3:0] ones_a  [2];
  logic       upd_a   [2];

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  snake_score_keeper #(.MAX_SCORE(99), .POINTS_PER_FOOD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .eat_pulse_i(eat), .game_over_i(go),
    .game_restart_i(rs), .frame_tick_i(tick), .score_o(score_a[0]),
    .score_tens_o(tens_a[0]), .score_ones_o(ones_a[0]),
    .score_update_o(upd_a[0]), .high_score_o(hs_a[0]));

  snake_score_keeper #(.MAX_SCORE(99), .POINTS_PER_FOOD(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .eat_pulse_i(eat), .game_over_i(go),
    .game_restart_i(rs), .frame_tick_i(tick), .score_o(score_a[1]),
    .score_tens_o(tens_a[1]), .score_ones_o(ones_a[1]),
    .score_update_o(upd_a[1]), .high_score_o(hs_a[1]));

  // Reference model: score rules, a conversion that takes 9 cycles from capture
  // to pending result (computed with / and %), and the frame latch.
  int m_score[2] = '{0, 0}, m_dirty[2] = '{0, 0}, m_cnt[2] = '{0, 0};
  int m_snap[2] = '{0, 0}, m_pt[2] = '{0, 0}, m_po[2] = '{0, 0}, m_pv[2] = '{0, 0};
  int m_dt[2] = '{0, 0}, m_do[2] = '{0, 0}, m_upd[2] = '{0, 0};
  int m_hs[2] = '{0, 0}, m_gop[2] = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_score[i] <= 0; m_dirty[i] <= 0; m_cnt[i] <= 0; m_snap[i] <= 0;
        m_pt[i] <= 0; m_po[i] <= 0; m_pv[i] <= 0; m_dt[i] <= 0; m_do[i] <= 0;
        m_upd[i] <= 0; m_hs[i] <= 0; m_gop[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        automatic int pts = (i == 0) ? 1 : 3;
        automatic int ns = m_score[i];
        automatic bit wr = 1'b0, cap = 1'b0, done = 1'b0, shown;
        if (rs) begin ns = 0; wr = 1'b1; end
        else if (eat && !go) begin
          ns = (m_score[i] + pts > 99) ? 99 : m_score[i] + pts;
          wr = 1'b1;
        end
        if (m_cnt[i] == 0) begin
          if (m_dirty[i] != 0) begin cap = 1'b1; m_snap[i] <= m_score[i]; m_cnt[i] <= 8; end
        end else if (m_cnt[i] == 1) begin done = 1'b1; m_cnt[i] <= 0; end
        else m_cnt[i] <= m_cnt[i] - 1;
        shown = tick && (m_pv[i] != 0);
        m_upd[i] <= shown;
        if (shown) begin m_dt[i] <= m_pt[i]; m_do[i] <= m_po[i]; end
        if (done) begin m_pt[i] <= m_snap[i] / 10; m_po[i] <= m_snap[i] % 10; m_pv[i] <= 1; end
        else if (shown) m_pv[i] <= 0;
        if (HS_EN && go && m_gop[i] == 0 && m_score[i] > m_hs[i]) m_hs[i] <= m_score[i];
        m_gop[i] <= go;
        m_dirty[i] <= wr ? 1 : (cap ? 0 : m_dirty[i]);
        m_score[i] <= ns;
      end
    end
  end

  task automatic chk(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[P=%0d] got=%0d exp=%0d at %0t", nm, (i == 0) ? 1 : 3, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("model_score", i, int'(score_a[i]), m_score[i]);
        chk("model_tens",  i, int'(tens_a[i]),  m_dt[i]);
        chk("model_ones",  i, int'(ones_a[i]),  m_do[i]);
        chk("model_upd",   i, int'(upd_a[i]),   m_upd[i]);
        chk("model_hs",    i, int'(hs_a[i]),    m_hs[i]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask
  task automatic eat1();
    @(posedge clk); #1 eat = 1'b1;
    @(posedge clk); #1 eat = 1'b0;
  endtask
  task automatic tick1();
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
  endtask
  task automatic restart1();
    @(posedge clk); #1 rs = 1'b1;
    @(posedge clk); #1 rs = 1'b0;
  endtask
  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    cyc(2); #1 rst_n = 1'b1;
  endtask
  task automatic eats(input int n);
    repeat (n) begin eat1(); cyc(2); end
  endtask
  task automatic chk_digits(input string nm, input int i, input int t, input int o, input int u);
    chk({nm, "_tens"}, i, int'(tens_a[i]), t);
    chk({nm, "_ones"}, i, int'(ones_a[i]), o);
    chk({nm, "_upd"},  i, int'(upd_a[i]),  u);
  endtask

  typedef struct {
    int n_eat; bit go; bit rs;
    int s1; int t1; int o1; int s3; int t3; int o3; bit upd;
  } vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{3,  1'b0, 1'b0,  3, 0, 3,  9, 0, 9, 1'b1};
    tbl[1] = '{1,  1'b1, 1'b0,  3, 0, 3,  9, 0, 9, 1'b0};
    tbl[2] = '{4,  1'b0, 1'b0,  7, 0, 7, 21, 2, 1, 1'b1};
    tbl[3] = '{0,  1'b0, 1'b1,  0, 0, 0,  0, 0, 0, 1'b1};
    tbl[4] = '{40, 1'b0, 1'b0, 40, 4, 0, 99, 9, 9, 1'b1};
    tbl[5] = '{12, 1'b0, 1'b0, 52, 5, 2, 99, 9, 9, 1'b1};

    cyc(3); #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_score", i, int'(score_a[i]), 0);
      chk_digits("rst", i, 0, 0, 0);
      chk("rst_hs", i, int'(hs_a[i]), 0);
    end

    // Table rows: optional restart, spaced eats, settle, one frame tick.
    for (int r = 0; r < 6; r++) begin
      @(posedge clk); #1 go = tbl[r].go;
      if (tbl[r].rs) restart1();
      eats(tbl[r].n_eat);
      cyc(20);
      tick1();
      @(negedge clk);
      chk("tbl_score", 0, int'(score_a[0]), tbl[r].s1);
      chk("tbl_score", 1, int'(score_a[1]), tbl[r].s3);
      chk_digits("tbl", 0, tbl[r].t1, tbl[r].o1, int'(tbl[r].upd));
      chk_digits("tbl", 1, tbl[r].t3, tbl[r].o3, int'(tbl[r].upd));
    end

    // Result completes in the same cycle as a frame tick.
    do_reset();
    eat1();
    cyc(8);
    #1 tick = 1'b1; @(posedge clk); #1 tick = 1'b0;
    @(negedge clk);
    chk_digits("coinc_first", 0, 0, 0, 0);
    chk_digits("coinc_first", 1, 0, 0, 0);
    cyc(3); tick1(); @(negedge clk);
    chk_digits("coinc_next", 0, 0, 1, 1);
    chk_digits("coinc_next", 1, 0, 3, 1);

    // Eat two cycles into the conversion of 41.
    do_reset();
    eats(40); cyc(20); tick1(); cyc(2);
    eat1(); @(posedge clk); eat1();
    @(negedge clk);
    chk("midconv_score", 0, int'(score_a[0]), 42);
    cyc(25); tick1(); @(negedge clk);
    chk_digits("midconv", 0, 4, 2, 1);

    // High score across a restart.
    do_reset();
    eats(57);
    @(posedge clk); #1 go = 1'b1;
    cyc(3); @(negedge clk);
    chk("hs_first", 0, int'(hs_a[0]), HS_EN ? 57 : 0);
    chk("hs_first", 1, int'(hs_a[1]), HS_EN ? 99 : 0);
    @(posedge clk); #1 go = 1'b0;
    restart1(); @(negedge clk);
    chk("restart_score", 0, int'(score_a[0]), 0);
    chk("restart_hs", 0, int'(hs_a[0]), HS_EN ? 57 : 0);
    eats(30);
    @(posedge clk); #1 go = 1'b1;
    cyc(3); @(negedge clk);
    chk("hs_second_score", 0, int'(score_a[0]), 30);
    chk("hs_second_score", 1, int'(score_a[1]), 90);
    chk("hs_second", 0, int'(hs_a[0]), HS_EN ? 57 : 0);
    chk("hs_second", 1, int'(hs_a[1]), HS_EN ? 99 : 0);
    @(posedge clk); #1 go = 1'b0;

    // Reset pulse in the middle of a conversion.
    do_reset();
    eat1(); cyc(3);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("midrst_score", i, int'(score_a[i]), 0);
      chk_digits("midrst", i, 0, 0, 0);
      chk("midrst_hs", i, int'(hs_a[i]), 0);
    end
    chk("midrst_busy", 0, int'(dut1.u_conv.busy_o), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(20); tick1(); @(negedge clk);
    chk_digits("after_rst", 0, 0, 0, 0);

    // Random traffic against the model.
    do_reset();
    repeat (4000) begin
      @(posedge clk);
      #1;
      eat   = ($urandom_range(3) == 0);
      rs    = ($urandom_range(96) == 0);
      tick  = ($urandom_range(12) == 0);
      if ($urandom_range(49) == 0) go = ~go;
      rst_n = ($urandom_range(799) != 0);
    end
    @(posedge clk); #1 eat = 1'b0; rs = 1'b0; tick = 1'b0; rst_n = 1'b1;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
